fee_arbiter: RTL and testbench
==============================

FEE_ARBITER -- requirements
Module: fee_arbiter

Interface
REQ-001 The block SHALL have parameter N_GATES, default 4, giving the number of exit-gate requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum WAIT cycles before a transaction is aborted.
REQ-003 The block SHALL have the following ports, one clock and asynchronous active-low reset:
clk  in  1  sole clock, rising edge
reset_n  in  1  asynchronous active-low reset
req  in  N_GATES  per-gate fee request, level, held until granted
gate_entry_time  in  32*N_GATES  packed per-gate entry time (s), gate i at [32i+31:32i]
gate_exit_time  in  32*N_GATES  packed per-gate exit time (s)
gate_vehicle_type  in  2*N_GATES  packed per-gate type (0 std, 1 premium, 2 reserved, 3 special)
grant  out  N_GATES  one-hot, one-cycle pulse: request accepted
fee_valid  out  N_GATES  one-hot, one-cycle pulse: fee_out valid for that gate
fee_err  out  N_GATES  one-hot, one-cycle pulse: transaction timed out
fee_out  out  32  fee result, valid with fee_valid/fee_err
busy  out  1  high whenever state is not IDLE
txn_count  out  16  completed transactions (valid or err), wraps at 0xFFFF->0
calc_entry_time  out  32  operand to shared calculator
calc_exit_time  out  32  operand to shared calculator
calc_vehicle_type  out  2  operand to shared calculator
calc_start  out  1  one-cycle calculate pulse
calc_fee  in  32  calculator result
calc_done  in  1  calculator completion, asserted the cycle after calc_start

Function
REQ-004 The state machine SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-005 In IDLE with any req bit high, on the next edge: select winner by round-robin starting at rr_ptr; latch winner's three operands into calc_* registers; pulse grant[winner] in the following cycle; go ISSUE.
REQ-006 ISSUE SHALL last exactly one cycle with calc_start=1; next state WAIT; wait counter cleared.
REQ-007 In WAIT, calc_done=1 SHALL capture calc_fee into fee_out and go RESP as a success.
REQ-008 In WAIT, counter reaching TIMEOUT_CYCLES without calc_done SHALL set fee_out=0 and go RESP as an error.
REQ-009 RESP SHALL last one cycle, pulsing fee_valid[winner] (success) or fee_err[winner] (error), incrementing txn_count, then go IDLE.
REQ-010 Latency: grant in cycle G, calc_start in G, fee_valid in G+3 with a one-cycle-latency calculator; one transaction per 4 cycles minimum.
REQ-011 rr_ptr SHALL become (winner+1) mod N_GATES at grant; with all requesting, grants cycle 0,1,2,3,0....
REQ-012 req changes outside IDLE SHALL be ignored; requesters deassert req after grant; a req still high in IDLE is regranted.
REQ-013 calc_done outside WAIT SHALL be ignored (late or stray results discarded).
REQ-014 calc_* operands SHALL hold stable from grant through RESP; gate inputs changing after grant SHALL not affect the result.
REQ-015 grant, fee_valid, fee_err SHALL never have more than one bit set; fee_valid and fee_err never together.

Reset
REQ-016 reset_n low SHALL asynchronously force: state IDLE, rr_ptr 0, all outputs 0 (grant, fee_valid, fee_err, fee_out, busy, txn_count, calc_*), wait counter 0.
REQ-017 Reset mid-transaction SHALL abandon it with no fee_valid/fee_err; a calc_done arriving after release is ignored per REQ-013.

Structure
REQ-018 Package fee_arb_pkg SHALL hold the state encoding, vehicle-type codes, and default N_GATES/TIMEOUT_CYCLES.
REQ-019 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs req, rr_ptr; outputs one-hot winner, index, any).

Verification
REQ-020 Gate 0 req, entry 0, exit 3600, type 0, real calculator -> grant[0], fee_valid[0] 3 cycles later, fee_out=15.
REQ-021 Gate 2 req, entry 100, exit 7300, type 1 -> fee_valid[2], fee_out=30; type 2 same times -> fee_out=50.
REQ-022 All four req high, held until own grant -> grants in order 0,1,2,3, each fee_valid 3 cycles after grant, txn_count=4.
REQ-023 calc_done tied 0 -> fee_err[winner] after 16 WAIT cycles, fee_out=0, no fee_valid, txn_count+1, back to IDLE.
REQ-024 reset_n low during WAIT, then calc_done pulse after release -> no fee_valid/fee_err, all outputs 0, rr_ptr 0.
REQ-025 Gate 1 inputs changed the cycle after grant[1] -> fee_out reflects operands at grant only.

Source files
------------

// File: rtl/fee_arb_pkg.sv
// Shared definitions for the parking-fee arbiter: FSM encoding, vehicle-type
// codes and default sizing.
package fee_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        VT_STD      = 2'd0,
        VT_PREMIUM  = 2'd1,
        VT_RESERVED = 2'd2,
        VT_SPECIAL  = 2'd3
    } vehicle_t;

    localparam int DEF_N_GATES        = 4;
    localparam int DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after rr_ptr,
// wrapping modulo N.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  winner,
    output logic [IW-1:0] index,
    output logic          any
);

    logic found;
    int   cand;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        index = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(rr_ptr) + k) % N;
            if (!found && req[cand]) begin
                found = 1'b1;
                index = IW'(cand);
            end
        end
        winner        = '0;
        winner[index] = found;
    end

    assign any = |req;

endmodule

// File: rtl/fee_arbiter.sv
// Arbitrates N exit gates onto one shared fee calculator; one transaction at a
// time through IDLE -> ISSUE -> WAIT -> RESP.
module fee_arbiter
    import fee_arb_pkg::*;
#(
    parameter int N_GATES        = DEF_N_GATES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_GATES-1:0]    req,
    input  logic [32*N_GATES-1:0] gate_entry_time,
    input  logic [32*N_GATES-1:0] gate_exit_time,
    input  logic [2*N_GATES-1:0]  gate_vehicle_type,
    output logic [N_GATES-1:0]    grant,
    output logic [N_GATES-1:0]    fee_valid,
    output logic [N_GATES-1:0]    fee_err,
    output logic [31:0]           fee_out,
    output logic                  busy,
    output logic [15:0]           txn_count,
    output logic [31:0]           calc_entry_time,
    output logic [31:0]           calc_exit_time,
    output logic [1:0]            calc_vehicle_type,
    output logic                  calc_start,
    input  logic [31:0]           calc_fee,
    input  logic                  calc_done
);

    localparam int IW = (N_GATES > 1) ? $clog2(N_GATES) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t         state, state_next;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  win_idx;
    logic [CW-1:0]  wait_cnt;
    logic           resp_err;

    logic [N_GATES-1:0] arb_winner;
    logic [IW-1:0]      arb_index;
    logic               arb_any;
    logic               timeout;

    rr_arbiter #(.N(N_GATES)) u_rr (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (arb_winner),
        .index  (arb_index),
        .any    (arb_any)
    );

    assign timeout = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign busy    = (state != ST_IDLE);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (arb_any) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (calc_done || timeout) state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= ST_IDLE;
            rr_ptr            <= '0;
            win_idx           <= '0;
            wait_cnt          <= '0;
            resp_err          <= 1'b0;
            grant             <= '0;
            fee_valid         <= '0;
            fee_err           <= '0;
            fee_out           <= '0;
            txn_count         <= '0;
            calc_entry_time   <= '0;
            calc_exit_time    <= '0;
            calc_vehicle_type <= '0;
            calc_start        <= 1'b0;
        end else begin
            state      <= state_next;
            grant      <= '0;
            fee_valid  <= '0;
            fee_err    <= '0;
            calc_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        // Operands are frozen here; later gate input changes cannot leak in.
                        win_idx           <= arb_index;
                        grant             <= arb_winner;
                        calc_start        <= 1'b1;
                        rr_ptr            <= (arb_index == IW'(N_GATES - 1)) ? '0 : arb_index + 1'b1;
                        calc_entry_time   <= gate_entry_time[arb_index*32 +: 32];
                        calc_exit_time    <= gate_exit_time[arb_index*32 +: 32];
                        calc_vehicle_type <= gate_vehicle_type[arb_index*2 +: 2];
                    end
                end
                ST_ISSUE: wait_cnt <= '0;
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (calc_done) begin
                        fee_out  <= calc_fee;
                        resp_err <= 1'b0;
                    end else if (timeout) begin
                        fee_out  <= '0;
                        resp_err <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_err) fee_err[win_idx]   <= 1'b1;
                    else          fee_valid[win_idx] <= 1'b1;
                    txn_count <= txn_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fee_arbiter.sv
// Directed bench for fee_arbiter with a one-cycle-latency fee calculator model.
module tb_fee_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  req;
    logic [31:0]   entry_t [N];
    logic [31:0]   exit_t  [N];
    logic [1:0]    vtype   [N];
    logic [32*N-1:0] gate_entry_time, gate_exit_time;
    logic [2*N-1:0]  gate_vehicle_type;
    logic [N-1:0]  grant, fee_valid, fee_err;
    logic [31:0]   fee_out;
    logic          busy;
    logic [15:0]   txn_count;
    logic [31:0]   calc_entry_time, calc_exit_time;
    logic [1:0]    calc_vehicle_type;
    logic          calc_start;
    logic [31:0]   calc_fee;
    logic          calc_done;

    logic calc_en;
    logic force_done;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   excl_viol = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            gate_entry_time[32*i +: 32]  = entry_t[i];
            gate_exit_time[32*i +: 32]   = exit_t[i];
            gate_vehicle_type[2*i +: 2]  = vtype[i];
        end
    end

    fee_arbiter #(.N_GATES(N), .TIMEOUT_CYCLES(16)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req               (req),
        .gate_entry_time   (gate_entry_time),
        .gate_exit_time    (gate_exit_time),
        .gate_vehicle_type (gate_vehicle_type),
        .grant             (grant),
        .fee_valid         (fee_valid),
        .fee_err           (fee_err),
        .fee_out           (fee_out),
        .busy              (busy),
        .txn_count         (txn_count),
        .calc_entry_time   (calc_entry_time),
        .calc_exit_time    (calc_exit_time),
        .calc_vehicle_type (calc_vehicle_type),
        .calc_start        (calc_start),
        .calc_fee          (calc_fee),
        .calc_done         (calc_done)
    );

    // Calculator stand-in: per started hour, 15 for std/premium, 25 reserved, 0 special.
    function automatic logic [31:0] calc_model(input logic [31:0] en, input logic [31:0] ex,
                                               input logic [1:0] t);
        logic [31:0] hours;
        hours = (ex - en + 32'd3599) / 32'd3600;
        case (t)
            2'd0, 2'd1: return hours * 32'd15;
            2'd2:       return hours * 32'd25;
            default:    return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            calc_done <= 1'b0;
            calc_fee  <= '0;
        end else begin
            calc_done <= (calc_start & calc_en) | force_done;
            calc_fee  <= force_done ? 32'hDEAD_BEEF
                                    : calc_model(calc_entry_time, calc_exit_time, calc_vehicle_type);
        end
    end

    always @(negedge clk) begin
        if ($countones(grant) > 1 || $countones(fee_valid) > 1 || $countones(fee_err) > 1 ||
            (|fee_valid && |fee_err))
            excl_viol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_gate(input int g, input logic [31:0] en, input logic [31:0] ex,
                            input logic [1:0] t);
        entry_t[g] = en;
        exit_t[g]  = ex;
        vtype[g]   = t;
    endtask

    task automatic wait_grant(input string tag, input logic [N-1:0] exp);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (grant != '0) break;
        end
        check({tag, "_grant"}, 32'(grant), 32'(exp));
        check({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_resp(input string tag, input int exp_lat, input bit exp_err,
                             input logic [N-1:0] exp_oh, input logic [31:0] exp_fee);
        int n;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n++;
            if (fee_valid != '0 || fee_err != '0) break;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_fee_valid"}, 32'(fee_valid), exp_err ? 32'd0 : 32'(exp_oh));
        check({tag, "_fee_err"}, 32'(fee_err), exp_err ? 32'(exp_oh) : 32'd0);
        check({tag, "_fee_out"}, fee_out, exp_fee);
    endtask

    task automatic run_txn(input string tag, input int g, input logic [31:0] exp_fee,
                           input bit exp_err, input bit mutate);
        logic [N-1:0] oh;
        oh = '0;
        oh[g] = 1'b1;
        req[g] = 1'b1;
        wait_grant(tag, oh);
        req[g] = 1'b0;
        if (mutate) set_gate(g, 32'd0, 32'd36000, 2'd2);
        wait_resp(tag, exp_err ? 18 : 3, exp_err, oh, exp_fee);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic [31:0] exp_fees [N];

    initial begin
        reset_n    = 1'b0;
        req        = '0;
        calc_en    = 1'b1;
        force_done = 1'b0;
        for (int i = 0; i < N; i++) set_gate(i, 32'd0, 32'd0, 2'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        check("rst_outputs", {grant, fee_valid, fee_err, 3'b000, busy, calc_start}, 32'd0);
        check("rst_fee_out", fee_out, 32'd0);
        check("rst_txn", 32'(txn_count), 32'd0);
        check("rst_calc_ops", calc_entry_time | calc_exit_time | 32'(calc_vehicle_type), 32'd0);

        // Single standard hour at gate 0.
        set_gate(0, 32'd0, 32'd3600, 2'd0);
        run_txn("g0_std", 0, 32'd15, 1'b0, 1'b0);
        check("g0_txn", 32'(txn_count), 32'd1);

        // Gate 2: two hours premium, then reserved.
        set_gate(2, 32'd100, 32'd7300, 2'd1);
        run_txn("g2_prem", 2, 32'd30, 1'b0, 1'b0);
        set_gate(2, 32'd100, 32'd7300, 2'd2);
        run_txn("g2_resv", 2, 32'd50, 1'b0, 1'b0);

        // Gate 1 operands altered right after grant must not change the fee.
        set_gate(1, 32'd0, 32'd3600, 2'd0);
        run_txn("g1_hold", 1, 32'd15, 1'b0, 1'b1);
        check("hold_txn", 32'(txn_count), 32'd4);

        // Calculator never answers: timeout error on gate 3.
        calc_en = 1'b0;
        set_gate(3, 32'd0, 32'd3600, 2'd0);
        run_txn("g3_tmo", 3, 32'd0, 1'b1, 1'b0);
        check("tmo_txn", 32'(txn_count), 32'd5);
        check("tmo_busy", 32'(busy), 32'd0);
        calc_en = 1'b1;

        // Reset, then all four gates requesting: strict 0,1,2,3 order.
        do_reset();
        check("rst2_txn", 32'(txn_count), 32'd0);
        set_gate(0, 32'd0,   32'd3600, 2'd0);
        set_gate(1, 32'd0,   32'd3601, 2'd0);
        set_gate(2, 32'd100, 32'd7300, 2'd1);
        set_gate(3, 32'd0,   32'd3600, 2'd2);
        exp_fees[0] = 32'd15;
        exp_fees[1] = 32'd30;
        exp_fees[2] = 32'd30;
        exp_fees[3] = 32'd25;
        req = 4'b1111;
        for (int i = 0; i < N; i++) begin
            logic [N-1:0] oh;
            oh = '0;
            oh[i] = 1'b1;
            wait_grant($sformatf("rr%0d", i), oh);
            req[i] = 1'b0;
            wait_resp($sformatf("rr%0d", i), 3, 1'b0, oh, exp_fees[i]);
        end
        check("rr_txn", 32'(txn_count), 32'd4);

        // Reset during WAIT, then a stray calc_done after release.
        calc_en = 1'b0;
        req[2] = 1'b1;
        wait_grant("abort", 4'b0100);
        req[2] = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_outputs", {grant, fee_valid, fee_err, 3'b000, busy, calc_start}, 32'd0);
        check("abort_fee_txn", fee_out | 32'(txn_count), 32'd0);
        check("abort_calc_ops", calc_entry_time | calc_exit_time | 32'(calc_vehicle_type), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        begin
            logic [N-1:0] seen;
            logic         busy_seen;
            seen = '0;
            busy_seen = 1'b0;
            repeat (6) begin
                @(negedge clk);
                seen = seen | fee_valid | fee_err;
                busy_seen = busy_seen | busy;
            end
            check("stray_resp", 32'(seen), 32'd0);
            check("stray_busy", 32'(busy_seen), 32'd0);
            check("stray_fee_out", fee_out, 32'd0);
        end
        calc_en = 1'b1;

        // rr_ptr back at 0: with gates 1 and 3 requesting, gate 1 wins.
        set_gate(1, 32'd0, 32'd3600, 2'd3);
        req = 4'b1010;
        wait_grant("ptr0", 4'b0010);
        req[1] = 1'b0;
        wait_resp("ptr0", 3, 1'b0, 4'b0010, 32'd0);
        req[3] = 1'b0;
        repeat (8) @(negedge clk);

        check("one_hot_exclusive", 32'(excl_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
